// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the comparison-pipe bench:
// state encodings, a width helper and the default word/strobe constants.
`timescale 1ns/1ps
package ser_pkg;

  localparam int SER_DW_DEFAULT      = 8;
  localparam int SER_CLK_DIV_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Bits needed to hold values 0..value-1, never less than one bit so that
  // degenerate configurations (CLK_DIV==1) still get a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle of the bit serializer.
// master: upstream word source and bit sink; slave: the serializer.
`timescale 1ns/1ps
interface bit_serializer_if
  import ser_pkg::*;
#(
  parameter int DW = SER_DW_DEFAULT
);

  logic          i_valid;
  logic [DW-1:0] i_word;
  logic          o_ready;
  logic          o_ce;
  logic          o_data;
  logic          o_busy;

  modport master (
    output i_valid, i_word,
    input  o_ready, o_ce, o_data, o_busy
  );

  modport slave (
    input  i_valid, i_word,
    output o_ready, o_ce, o_data, o_busy
  );

endinterface

// File: rtl/bit_serializer_ce_divider.sv
// Modulo-DIV strobe divider: counts while enabled, wraps at DIV-1 and flags
// that terminal count combinationally. A synchronous clear restarts the period.
`timescale 1ns/1ps
module ce_divider
  import ser_pkg::*;
#(
  parameter int DIV = SER_CLK_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int            CW   = clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Terminal only counts while enabled so an idle serializer never strobes.
  assign o_tc = i_en && (div_cnt == TERM);

  // Period counter: clear wins, then wrap at terminal, else count when enabled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values and the order of statements cannot create races.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt <= '0;
    end else if (i_clr || o_tc) begin
      div_cnt <= '0;
    end else if (i_en) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef FORMAL
  // The counter never climbs past its terminal value.
  always_comb begin
    if (i_reset_n) assert (div_cnt <= TERM);
  end
`endif

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stimulus stage: accepts words on a valid/ready handshake
// and emits them one bit per o_ce strobe, one strobe every CLK_DIV cycles.
// Back-to-back words stream gaplessly (next word accepted on the last strobe).
// Build option: define SER_PARITY_EN to append an even-parity bit per word.
// FORMAL enables internal range and protocol assertions.
`timescale 1ns/1ps
module bit_serializer
  import ser_pkg::*;
#(
  parameter int DW        = SER_DW_DEFAULT,
  parameter int CLK_DIV   = SER_CLK_DIV_DEFAULT,
  parameter int LSB_FIRST = 1
) (
  input logic             i_clk,
  input logic             i_reset_n,
  bit_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int NBITS = DW + 1;
`else
  localparam int NBITS = DW;
`endif

  localparam int             BCW      = clog2(DW + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);

  ser_state_e     state_q;
  ser_state_e     state_d;
  logic [BCW-1:0] bit_cnt;
  logic [DW-1:0]  sreg;
  logic [DW-1:0]  sreg_shifted;
  logic           ce_q;
  logic           data_q;
  logic           next_bit;
  logic           tc;
  logic           last_term;
  logic           ready;
  logic           accept;
  logic           div_en;
`ifdef SER_PARITY_EN
  localparam logic [BCW-1:0] PAR_BIT = BCW'(DW);
  logic parity_q;
`endif

  // Strobe timing lives in the divider; it restarts its period on every accept.
  ce_divider #(
    .DIV (CLK_DIV)
  ) u_ce_divider (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (div_en),
    .i_clr     (accept),
    .o_tc      (tc)
  );

  assign last_term = tc && (bit_cnt == LAST_BIT);
  assign accept    = bus.i_valid && ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state: leave IDLE on accept, return only when the last bit goes out
  // with no follow-on word waiting.
  // NOTE: state_d gets a default first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)                 state_d = ST_SHIFT;
      ST_SHIFT: if (last_term && !accept)   state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE or on the final terminal cycle of a word.
  always_comb begin
    div_en = (state_q == ST_SHIFT);
    ready  = (state_q == ST_IDLE) || last_term;
  end

  // Bit presented at the send end of the shift register (or the parity bit).
  always_comb begin
    next_bit = (LSB_FIRST != 0) ? sreg[0] : sreg[DW-1];
`ifdef SER_PARITY_EN
    if (bit_cnt == PAR_BIT) next_bit = parity_q;
`endif
  end

  assign sreg_shifted = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);

  // Datapath: load on accept, shift and strobe on each terminal count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      ce_q     <= 1'b0;
      data_q   <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      ce_q <= tc;
      if (tc) data_q <= next_bit;
      if (accept) begin
        sreg     <= bus.i_word;
        bit_cnt  <= '0;
`ifdef SER_PARITY_EN
        parity_q <= ^bus.i_word;
`endif
      end else if (tc) begin
        sreg    <= sreg_shifted;
        bit_cnt <= last_term ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_ce    = ce_q;
  assign bus.o_data  = data_q;
  assign bus.o_busy  = (state_q == ST_SHIFT);

`ifdef FORMAL
  logic [BCW-1:0] f_strobes;

  // Terminal counts seen since the current word was accepted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  f_strobes <= '0;
    else if (accept) f_strobes <= '0;
    else if (tc)     f_strobes <= f_strobes + 1'b1;
  end

  a_bit_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bit_cnt <= LAST_BIT);
  a_per_word: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    last_term |-> (f_strobes == LAST_BIT));
  a_data_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !$stable(data_q) |-> ce_q);
  if (CLK_DIV > 1) begin : g_ce_gap
    a_ce_gap: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      ce_q |=> !ce_q);
  end
`endif

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Upstream stimulus stage for the dual-LFSR comparison pipe. Accepts parallel words over a valid/ready handshake and emits them one bit at a time. Each bit is qualified by a single-cycle clock-enable strobe at a programmable rate. o_ce/o_data drive the comparison pipe's i_ce/i_data directly.

Parameters:
DW, 8, data word width in bits (>=2)
CLK_DIV, 4, clock cycles between successive o_ce strobes (>=1)
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit DW-1 sent first

Ports:
i_clk  input  1  system clock, all state on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_valid  input  1  i_word valid this cycle
i_word  input  DW  parallel word to serialize
o_ready  output  1  word accepted on an edge where i_valid && o_ready
o_ce  output  1  one-cycle strobe; o_data valid while high
o_data  output  1  serialized bit, changes only together with o_ce
o_busy  output  1  high while a word is in flight (state SHIFT)

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ce=0, o_data=0, o_busy=0, counters=0, shift reg=0.
- Registers: state {IDLE, SHIFT}, div_cnt [clog2(CLK_DIV) bits], bit_cnt [clog2(DW+1) bits], sreg [DW].
- o_ready is combinational: 1 in IDLE; 1 in SHIFT only on the last-bit terminal cycle (div_cnt==CLK_DIV-1 && bit_cnt==NBITS-1); else 0. NBITS = DW, or DW+1 with the optional feature.
- IDLE:
  - On accept: sreg<=i_word, div_cnt<=0, bit_cnt<=0, go SHIFT.
  - No accept: o_ce stays 0 and o_data holds.
- SHIFT:
  - div_cnt increments each cycle.
  - At div_cnt==CLK_DIV-1 (terminal): div_cnt<=0, o_ce<=1, o_data<=next bit, sreg shifts toward the send end, bit_cnt++.
  - o_ce<=0 on all other cycles.
- Last-bit terminal:
  - With accept: load the new word, bit_cnt<=0, stay SHIFT. Gapless stream, strobe period stays exactly CLK_DIV.
  - Without accept: go IDLE.
- Latency: for acceptance on edge E0, the first o_ce is high in the cycle following edge E(CLK_DIV). Subsequent strobes follow every CLK_DIV cycles; exactly NBITS strobes per word.
- CLK_DIV==1: o_ce stays continuously high during a word and across back-to-back words.
- i_valid while o_ready=0: ignored. Upstream must hold the word; it is not latched.
- i_word changes after acceptance: no effect on the word in flight.
- o_busy = (state==SHIFT), registered with state.
- Reset mid-word: in-flight word discarded, o_ce drops immediately (async), restart from IDLE.
- Counters never wrap past terminal values. Out-of-range values are unreachable, and an assertion checks this under FORMAL.
- Formal properties:
  - o_ce never high in two consecutive cycles unless CLK_DIV==1.
  - Strobes per word == NBITS.
  - o_data stable when o_ce==0.

Optional Feature:
Macro SER_PARITY_EN.
- Defined: after the DW data bits, one extra strobe carries even parity (XOR of the accepted word), so NBITS=DW+1. Parity is computed and stored at acceptance.
- Undefined: NBITS=DW, no parity logic or storage.

Decomposition:
- Shared package/include ser_pkg: state encodings (ST_IDLE, ST_SHIFT), width helper clog2 function, default DW/CLK_DIV constants shared with the comparison-pipe testbench.
- One sub-module, ce_divider: a free-running-when-enabled modulo-CLK_DIV counter with synchronous clear and a terminal-count output. The serializer instantiates it with enable=(state==SHIFT) and clear=accept.

Test Plan:
1. DW=8, CLK_DIV=4, LSB_FIRST=1, accept 8'hA5 at E0 -> o_ce high in cycles after E4, E8, ..., E32; o_data sequence 1,0,1,0,0,1,0,1; o_busy low after the last strobe; o_ready high from the terminal cycle onward.
2. Back-to-back: 8'hFF then 8'h00 with i_valid held -> second word accepted on the first word's last terminal cycle; 16 strobes at uniform 4-cycle period; o_data 8×1 then 8×0.
3. i_valid pulsed with 8'h3C while busy with 8'h81 -> 8'h3C not accepted; output exactly 8'h81's bits; o_ready=0 throughout mid-word.
4. i_reset_n asserted low after the 3rd strobe of 8'hF0 -> o_ce/o_data/o_busy go to 0 immediately. After release, 8'h0F is sent cleanly; no residual bits from 8'hF0.
5. CLK_DIV=1, LSB_FIRST=0, word 8'hC3 -> o_ce high for 8 consecutive cycles starting the cycle after E1; o_data 1,1,0,0,0,0,1,1.
6. SER_PARITY_EN defined, word 8'h07 -> 9 strobes; data 1,1,1,0,0,0,0,0 then parity 1. Word 8'h03 -> parity bit 0.
